// File: rtl/uart_rx_multi.sv
// rtl/uart_rx_multi.sv - oversampling UART receiver with runtime-selectable framing
// Optional break detection (Break_det port) enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Parity_en,
  input  logic                  Parity_type,
  input  logic                  Stop_bits,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  Parity_error,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  Stop_error,
  output logic                  Break_det
`else
  output logic                  Stop_error
`endif
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                state, state_nxt;
  logic [4:0]            edge_cnt;
  logic [3:0]            bit_cnt;
  logic [4:0]            ps_half_q, ps_last_q, ps_half_in, ps_last_in;
  logic [31:0]           ps_ext;
  logic                  par_en_q, par_type_q, stop2_q;
  logic [1:0]            samp;
  logic                  bit_q, par_bit, stop_acc;
  logic [DATA_WIDTH-1:0] shreg;

  logic active, sample_now, maj, cur_bit, bit_end, last_stop;
  logic start_now, frame_end, stop_err_f, par_err_f, frame_ok;
  logic idle_block, done_block;

  // Only 4/8/16/32 are supported ratios; anything else runs as 8.
  assign ps_ext = 32'(Prescale);
  always_comb begin
    ps_half_in = 5'd4;
    ps_last_in = 5'd7;
    case (ps_ext)
      32'd4:   begin ps_half_in = 5'd2;  ps_last_in = 5'd3;  end
      32'd16:  begin ps_half_in = 5'd8;  ps_last_in = 5'd15; end
      32'd32:  begin ps_half_in = 5'd16; ps_last_in = 5'd31; end
      default: begin ps_half_in = 5'd4;  ps_last_in = 5'd7;  end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!RX_IN && !idle_block) state_nxt = START;
      START:   if (bit_end) state_nxt = cur_bit ? IDLE : DATA;
      DATA:    if (bit_end && bit_cnt == 4'(DATA_WIDTH-1)) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = DONE;
      DONE:    state_nxt = (!RX_IN && !done_block) ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The third centre sample may coincide with the bit's last edge (Prescale=4),
  // so the vote is formed combinationally from the live line.
  always_comb begin
    active     = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    sample_now = active && (edge_cnt == ps_half_q + 5'd1);
    maj        = (samp[1] & samp[0]) | (samp[1] & RX_IN) | (samp[0] & RX_IN);
    cur_bit    = sample_now ? maj : bit_q;
    bit_end    = active && (edge_cnt == ps_last_q);
    last_stop  = (bit_cnt == {3'b000, stop2_q});
    start_now  = (state_nxt == START) && ((state == IDLE) || (state == DONE));
    frame_end  = (state == STOP) && bit_end && last_stop;
    stop_err_f = stop_acc | ~cur_bit;
    par_err_f  = par_en_q && ((^shreg ^ par_bit) != par_type_q);
    frame_ok   = !par_err_f && !stop_err_f;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      ps_half_q    <= 5'd4;
      ps_last_q    <= 5'd7;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      stop2_q      <= 1'b0;
      samp         <= '0;
      bit_q        <= 1'b0;
      par_bit      <= 1'b0;
      stop_acc     <= 1'b0;
      shreg        <= '0;
      P_DATA       <= '0;
      DATA_VALID   <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
    end else begin
      // The detecting sample is edge 0 of the start bit, so counting resumes at 1.
      if (start_now) begin
        edge_cnt   <= 5'd1;
        bit_cnt    <= '0;
        ps_half_q  <= ps_half_in;
        ps_last_q  <= ps_last_in;
        par_en_q   <= Parity_en;
        par_type_q <= Parity_type;
        stop2_q    <= Stop_bits;
        stop_acc   <= 1'b0;
      end else if (!active) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= (state_nxt == state) ? bit_cnt + 4'd1 : 4'd0;
      end else begin
        edge_cnt <= edge_cnt + 5'd1;
      end

      if (active && ((edge_cnt == ps_half_q - 5'd1) || (edge_cnt == ps_half_q)))
        samp <= {samp[0], RX_IN};
      if (sample_now) bit_q <= maj;

      if (bit_end) begin
        case (state)
          DATA:    shreg    <= {cur_bit, shreg[DATA_WIDTH-1:1]};
          PARITY:  par_bit  <= cur_bit;
          STOP:    stop_acc <= stop_acc | ~cur_bit;
          default: ;
        endcase
      end

      DATA_VALID <= frame_end && frame_ok;
      if (frame_end) begin
        Parity_error <= par_err_f;
        Stop_error   <= stop_err_f;
        if (frame_ok) P_DATA <= shreg;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic first_stop0, hold, first0_f, brk_f;

  assign first0_f   = (bit_cnt == 4'd0) ? ~cur_bit : first_stop0;
  assign brk_f      = (shreg == '0) && !(par_en_q && par_bit) && first0_f;
  assign idle_block = hold;
  assign done_block = Break_det;

  // After a break the line must be seen idle before another start is accepted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Break_det   <= 1'b0;
      first_stop0 <= 1'b0;
      hold        <= 1'b0;
    end else begin
      Break_det <= frame_end && brk_f;
      if ((state == STOP) && bit_end && (bit_cnt == 4'd0)) first_stop0 <= ~cur_bit;
      if ((state == DONE) && Break_det) hold <= 1'b1;
      else if (RX_IN)                    hold <= 1'b0;
    end
  end
`else
  assign idle_block = 1'b0;
  assign done_block = 1'b0;
`endif

endmodule
